mtr_drv: RTL

MTR_DRV -- requirements
Module: mtr_drv

---
 rtl/mtr_drv_pkg.sv | 12 +
 rtl/nonoverlap.sv | 57 +++++
 rtl/mtr_drv.sv | 55 +++++
 3 files changed

// File: rtl/mtr_drv_pkg.sv
// mtr_drv_pkg: shared gate-FSM states, PWM period width and duty mapping for the motor driver.
package mtr_drv_pkg;
  typedef enum logic [1:0] {OFF, DEAD, HI, LO} nov_state_e;
  localparam int CNT_W = 11;
  localparam logic [10:0] DUTY_MID = 11'h400;
  // Clamp to +/-0x3FF so duty stays in 0x001..0x7FF, then offset by mid-scale.
  function automatic logic [10:0] duty_of(input logic signed [11:0] spd);
    logic signed [11:0] s;
    s = (spd > 12'sh3FF) ? 12'sh3FF : (spd < -12'sh3FF) ? -12'sh3FF : spd;
    return 11'(s) + DUTY_MID;
  endfunction
endpackage

// File: rtl/nonoverlap.sv
// nonoverlap: per-channel gate FSM inserting NONOVERLAP dead cycles around every raw PWM edge.
module nonoverlap
  import mtr_drv_pkg::*;
#(
  parameter logic [5:0] NONOVERLAP = 6'h20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_raw,
  output logic o_pwm1,
  output logic o_pwm2
);
  nov_state_e r_st;
  logic [5:0] r_tmr;
  logic       r_prev, r_pwm1, r_pwm2;
  assign o_pwm1 = r_pwm1;
  assign o_pwm2 = r_pwm2;
  // Timer holds the number of cycles already spent in DEAD, so it starts at 1 on entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_st   <= OFF;
      r_tmr  <= '0;
      r_prev <= 1'b0;
      r_pwm1 <= 1'b0;
      r_pwm2 <= 1'b0;
    end else begin
      r_prev <= i_raw;
      if (!i_en) begin
        r_st   <= OFF;
        r_tmr  <= '0;
        r_pwm1 <= 1'b0;
        r_pwm2 <= 1'b0;
      end else
        case (r_st)
          OFF: begin
            r_st  <= DEAD;
            r_tmr <= 6'd1;
          end
          DEAD:
            if (i_raw != r_prev) r_tmr <= 6'd1;
            else if (r_tmr == NONOVERLAP) begin
              r_st   <= i_raw ? HI : LO;
              r_pwm1 <= i_raw;
              r_pwm2 <= !i_raw;
            end else r_tmr <= r_tmr + 6'd1;
          HI, LO:
            if (i_raw != (r_st == HI)) begin
              r_st   <= DEAD;
              r_tmr  <= 6'd1;
              r_pwm1 <= 1'b0;
              r_pwm2 <= 1'b0;
            end
          default: r_st <= OFF;
        endcase
    end
endmodule

// File: rtl/mtr_drv.sv
// mtr_drv: dual H-bridge PWM driver with saturated duty, period-aligned duty updates
// and dead-time insertion on every gate transition.
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter logic [5:0] NONOVERLAP = 6'h20,
  parameter bit         FAST_SIM   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2,
  output logic        pwm_sync
);
  localparam int W = FAST_SIM ? 8 : CNT_W;
  logic [W-1:0] r_cnt;
  logic [10:0]  r_lduty, r_rduty, w_lduty, w_rduty;
  logic         r_en_d, r_lraw, r_rraw, r_sync, w_latch;
  assign pwm_sync = r_sync;
  // New duty is visible to the comparator on the latch cycle itself, so an en rise starts cleanly.
  always_comb begin
    w_latch = en && (!r_en_d || (&r_cnt));
    w_lduty = w_latch ? duty_of(lft_spd) : r_lduty;
    w_rduty = w_latch ? duty_of(rght_spd) : r_rduty;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_en_d  <= 1'b0;
      r_lduty <= DUTY_MID;
      r_rduty <= DUTY_MID;
      r_lraw  <= 1'b0;
      r_rraw  <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_en_d  <= en;
      r_cnt   <= en ? r_cnt + W'(1) : '0;
      r_lduty <= w_lduty;
      r_rduty <= w_rduty;
      r_lraw  <= en && (r_cnt < w_lduty[10 -: W]);
      r_rraw  <= en && (r_cnt < w_rduty[10 -: W]);
      r_sync  <= en && (&r_cnt);
    end
  nonoverlap #(.NONOVERLAP(NONOVERLAP)) u_lft (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_raw(r_lraw), .o_pwm1(lftPWM1), .o_pwm2(lftPWM2)
  );
  nonoverlap #(.NONOVERLAP(NONOVERLAP)) u_rght (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_raw(r_rraw), .o_pwm1(rghtPWM1), .o_pwm2(rghtPWM2)
  );
endmodule
